apb_completer_regs: RTL and testbench
=====================================

APB_COMPLETER_REGS -- requirements
Module: apb_completer_regs

Interface
REQ-001 Parameters SHALL be NUM_REGS, default 16, number of 32-bit registers (power of two, 2..64).
REQ-002 Parameter WAIT_CYCLES SHALL default to 2 and set the number of wait-state access cycles per transfer (0..15).
REQ-003 Parameter ID_VALUE SHALL default to 32'hA9B0_0001 and set the read-only content of register 0.
REQ-004 Port pclk SHALL be an input, 1 bit, and the single clock; all state updates on its rising edge.
REQ-005 Port presetn SHALL be an input, 1 bit, and the reset: asynchronous, active-low.
REQ-006 Port pselx SHALL be an input, 1 bit, and the completer select.
REQ-007 Port penable SHALL be an input, 1 bit, and the access-phase indicator.
REQ-008 Port pwrite SHALL be an input, 1 bit: 1 = write, 0 = read.
REQ-009 Port paddr SHALL be an input, 32 bits, and the byte address.
REQ-010 Port pwdata SHALL be an input, 32 bits, and the write data.
REQ-011 Port pstrb SHALL be an input, 4 bits, and the write byte enables (bit n covers pwdata[8n+7:8n]).
REQ-012 Port prdata SHALL be an output, 32 bits, and the read data.
REQ-013 Port pready SHALL be an output, 1 bit, and the transfer-complete indicator.
REQ-014 Port pslverr SHALL be an output, 1 bit, and the error response.

Function
REQ-015 The FSM SHALL have states IDLE and ACCESS and a 4-bit wait counter.
- IDLE -> ACCESS when pselx=1 and penable=0 (setup phase); counter loads WAIT_CYCLES.
REQ-016 In ACCESS with pselx=1 and penable=1 and counter != 0, the counter SHALL decrement and pready SHALL be 0.
REQ-017 In ACCESS with pselx=1, penable=1 and counter=0, pready SHALL be 1 (completing cycle).
- Completing cycle = WAIT_CYCLES+1 cycles after the setup cycle.
- After the completing cycle: next state ACCESS with counter reloaded if pselx=1 and penable=0 (back-to-back), else IDLE.
REQ-018 In ACCESS with pselx=0 or penable=0 before completion (protocol abort), the FSM SHALL return to IDLE with no register update, unless this is a new setup phase (REQ-017 rule applies).
REQ-019 Decode SHALL use word index paddr[log2(NUM_REGS)+1:2].
- Error if paddr[1:0]!=0.
- Error if any paddr bit above the index field is nonzero.
- Error if the access is a write with index 0.
REQ-020 pslverr SHALL equal the decode error during the completing cycle only and SHALL be 0 at all other times.
REQ-021 A write SHALL commit on the completing-cycle edge when there is no error, updating only the bytes with pstrb=1; pstrb=4'b0000 SHALL complete without error or change.
REQ-022 An erroring write SHALL leave all registers unchanged.
REQ-023 During a read completing cycle, prdata SHALL carry the addressed register (ID_VALUE for index 0); prdata SHALL be 0 when there is an error and at all other times.
REQ-024 Reads SHALL have no side effects; pstrb SHALL be ignored on reads.
REQ-025 pready and pslverr SHALL be 0 in IDLE.

Reset
REQ-026 presetn=0 SHALL immediately force:
- state to IDLE and the counter to 0;
- pready, pslverr and prdata to 0;
- registers 1..NUM_REGS-1 to 32'h0.
REQ-027 Reset during ACCESS SHALL abort the transfer with no register update; the first setup phase after presetn rises SHALL be handled normally.

Verification
REQ-028 Write 0x04, pwdata=0xDEADBEEF, pstrb=4'hF, WAIT_CYCLES=2 -> pready=1 exactly 3 cycles after setup, pslverr=0; a subsequent read of 0x04 returns 0xDEADBEEF.
REQ-029 After REQ-028, write 0x04, pwdata=0x11223344, pstrb=4'b0101 -> read of 0x04 returns 0xDE22BE44.
REQ-030 Read 0x00 -> prdata=0xA9B00001; write 0x00 -> pslverr=1 and a following read still returns 0xA9B00001.
REQ-031 Read 0x06 (misaligned) and read 0x40 (out of range with NUM_REGS=16) -> pslverr=1 and prdata=0 in the completing cycle.
REQ-032 Back-to-back write 0x08 then read 0x08 with no idle cycle between -> both complete, each with WAIT_CYCLES wait states, and the read returns the written data.
REQ-033 Assert presetn=0 in the middle of the wait states of a write to 0x0C -> pready=0 at once; a later read of 0x0C returns 0x00000000.

Source files
------------

// File: rtl/apb_completer_regs.sv
// APB completer with a read-only ID word at index 0 and NUM_REGS-1 R/W words.
// Fixed wait states per transfer, byte strobes, and decode errors on bad addresses.
module apb_completer_regs #(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        pselx,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int IDXW = $clog2(NUM_REGS);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [IDXW-1:0]   w_idx;
    logic              w_err;
    logic              w_done;
    logic              w_setup;
    logic [31:0]       w_rdata;
    logic [31:0]       r_regs [1:NUM_REGS-1];

    assign w_idx   = paddr[IDXW+1:2];
    assign w_setup = pselx && !penable;

    assign w_err = (paddr[1:0] != 2'b00)
                 | (paddr[31:IDXW+2] != '0)
                 | (pwrite && (w_idx == '0));

    assign w_done = (r_state == S_ACCESS) && pselx && penable
                  && (r_cnt == 4'd0);

    always_comb begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
        unique case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = 4'(WAIT_CYCLES);
                end
            end
            S_ACCESS: begin
                // A fresh setup phase restarts the transfer; anything else
                // that is not a wait state completes or aborts to idle.
                if (w_setup) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = 4'(WAIT_CYCLES);
                end else if (pselx && penable && (r_cnt != 4'd0)) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_rdata = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (w_idx == IDXW'(i)) w_rdata = r_regs[i];
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= 32'h0;
        end else if (w_done && pwrite && !w_err) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_idx == IDXW'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (pstrb[b]) r_regs[i][8*b +: 8] <= pwdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign pready  = w_done;
    assign pslverr = w_done && w_err;
    assign prdata  = (w_done && !pwrite && !w_err) ? w_rdata : 32'h0;

endmodule

// File: tb/tb_apb_completer_regs.sv
// Directed bench for apb_completer_regs: timing, strobes, decode errors,
// back-to-back transfers, protocol abort and reset during a transfer.
module tb_apb_completer_regs;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int vecs = 0;
    int errs = 0;

    apb_completer_regs dut (
        .pclk    (pclk),
        .presetn (presetn),
        .pselx   (pselx),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 pclk = ~pclk;

    // Setup + access phases; returns access cycles up to and including the
    // completing one (-1 on timeout) and whether waits kept outputs at zero.
    task automatic xfer(input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic er,
                        output int cyc, output logic clean);
        @(negedge pclk);
        pselx = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = a; pwdata = d; pstrb = s;
        #1;
        clean = !pready && !pslverr && (prdata == 32'h0);
        cyc = -1; rd = 32'h0; er = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge pclk);
            penable = 1'b1;
            #1;
            if (pready) begin
                rd = prdata; er = pslverr; cyc = i;
                break;
            end
            if (pslverr || (prdata != 32'h0)) clean = 1'b0;
        end
    endtask

    task automatic idle();
        @(negedge pclk);
        pselx = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        pselx = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        #1;
        vecs++;
        if (pready !== 1'b0) begin
            errs++; $display("FAIL reset_pready got=%b exp=0", pready);
        end
        vecs++;
        if (pslverr !== 1'b0) begin
            errs++; $display("FAIL reset_pslverr got=%b exp=0", pslverr);
        end
        vecs++;
        if (prdata !== 32'h0) begin
            errs++; $display("FAIL reset_prdata got=%h exp=0", prdata);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int cyc; logic cl;
        xfer(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, rd, er, cyc, cl);
        vecs++;
        if (cyc !== 3) begin
            errs++; $display("FAIL wr04_latency got=%0d exp=3", cyc);
        end
        vecs++;
        if (er !== 1'b0 || cl !== 1'b1) begin
            errs++; $display("FAIL wr04_resp err=%b clean=%b exp err=0 clean=1", er, cl);
        end
        idle();
        #1;
        vecs++;
        if (pready !== 1'b0 || pslverr !== 1'b0) begin
            errs++; $display("FAIL idle_outputs rdy=%b err=%b exp 0 0", pready, pslverr);
        end
        xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc, cl);
        vecs++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || cyc !== 3) begin
            errs++; $display("FAIL rd04 got=%h err=%b cyc=%0d exp=deadbeef 0 3", rd, er, cyc);
        end
        idle();
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic er; int cyc; logic cl;
        xfer(1'b1, 32'h04, 32'h11223344, 4'b0101, rd, er, cyc, cl);
        idle();
        xfer(1'b0, 32'h04, 32'h0, 4'hF, rd, er, cyc, cl);
        vecs++;
        if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
            errs++; $display("FAIL strb0101 got=%h err=%b exp=de22be44 0", rd, er);
        end
        idle();
        xfer(1'b1, 32'h04, 32'hFFFFFFFF, 4'b0000, rd, er, cyc, cl);
        vecs++;
        if (er !== 1'b0 || cyc !== 3) begin
            errs++; $display("FAIL strb0000_resp err=%b cyc=%0d exp 0 3", er, cyc);
        end
        idle();
        xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc, cl);
        vecs++;
        if (rd !== 32'hDE22BE44) begin
            errs++; $display("FAIL strb0000_data got=%h exp=de22be44", rd);
        end
        idle();
    endtask

    task automatic test_id();
        logic [31:0] rd; logic er; int cyc; logic cl;
        xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er, cyc, cl);
        vecs++;
        if (rd !== 32'hA9B00001 || er !== 1'b0) begin
            errs++; $display("FAIL id_read got=%h err=%b exp=a9b00001 0", rd, er);
        end
        idle();
        xfer(1'b1, 32'h00, 32'h12345678, 4'hF, rd, er, cyc, cl);
        vecs++;
        if (er !== 1'b1) begin
            errs++; $display("FAIL id_write_err got=%b exp=1", er);
        end
        idle();
        xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er, cyc, cl);
        vecs++;
        if (rd !== 32'hA9B00001) begin
            errs++; $display("FAIL id_after_write got=%h exp=a9b00001", rd);
        end
        idle();
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int cyc; logic cl;
        xfer(1'b0, 32'h06, 32'h0, 4'h0, rd, er, cyc, cl);
        vecs++;
        if (er !== 1'b1 || rd !== 32'h0 || cyc !== 3) begin
            errs++; $display("FAIL rd_misalign err=%b data=%h cyc=%0d exp 1 0 3", er, rd, cyc);
        end
        idle();
        xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, er, cyc, cl);
        vecs++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errs++; $display("FAIL rd_range err=%b data=%h exp 1 0", er, rd);
        end
        idle();
        // 0x44 would alias index 1 if the upper address bits were ignored
        xfer(1'b1, 32'h44, 32'h55555555, 4'hF, rd, er, cyc, cl);
        vecs++;
        if (er !== 1'b1) begin
            errs++; $display("FAIL wr_range_err got=%b exp=1", er);
        end
        idle();
        xfer(1'b1, 32'h0A, 32'h66666666, 4'hF, rd, er, cyc, cl);
        vecs++;
        if (er !== 1'b1) begin
            errs++; $display("FAIL wr_misalign_err got=%b exp=1", er);
        end
        idle();
        xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc, cl);
        vecs++;
        if (rd !== 32'hDE22BE44) begin
            errs++; $display("FAIL err_no_write got=%h exp=de22be44", rd);
        end
        idle();
        xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er, cyc, cl);
        vecs++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errs++; $display("FAIL err_no_write08 got=%h err=%b exp=0 0", rd, er);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int c1; int c2; logic cl;
        xfer(1'b1, 32'h08, 32'hCAFEF00D, 4'hF, rd, er, c1, cl);
        xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er, c2, cl);
        vecs++;
        if (c1 !== 3 || c2 !== 3) begin
            errs++; $display("FAIL b2b_latency got=%0d/%0d exp=3/3", c1, c2);
        end
        vecs++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0 || cl !== 1'b1) begin
            errs++; $display("FAIL b2b_data got=%h err=%b clean=%b exp=cafef00d 0 1", rd, er, cl);
        end
        idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int cyc; logic cl;
        @(negedge pclk);
        pselx = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'hBADBAD00; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        idle();
        repeat (3) @(negedge pclk);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc, cl);
        vecs++;
        if (rd !== 32'h0 || cyc !== 3) begin
            errs++; $display("FAIL abort_no_write got=%h cyc=%0d exp=0 3", rd, cyc);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int cyc; logic cl;
        // Reset landing on a completing read cycle must drop outputs at once
        xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er, cyc, cl);
        #1 presetn = 1'b0;
        #1;
        vecs++;
        if (pready !== 1'b0 || prdata !== 32'h0) begin
            errs++; $display("FAIL rst_async rdy=%b data=%h exp 0 0", pready, prdata);
        end
        idle();
        presetn = 1'b1;
        @(negedge pclk);
        pselx = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h0C; pwdata = 32'h87654321; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        #1 presetn = 1'b0;
        #1;
        vecs++;
        if (pready !== 1'b0 || pslverr !== 1'b0) begin
            errs++; $display("FAIL rst_wait rdy=%b err=%b exp 0 0", pready, pslverr);
        end
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        #1;
        vecs++;
        if (pready !== 1'b0) begin
            errs++; $display("FAIL rst_hold_idle rdy=%b exp 0", pready);
        end
        idle();
        xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd, er, cyc, cl);
        vecs++;
        if (rd !== 32'h0 || er !== 1'b0 || cyc !== 3) begin
            errs++; $display("FAIL rst_rd0c got=%h err=%b cyc=%0d exp=0 0 3", rd, er, cyc);
        end
        idle();
        xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er, cyc, cl);
        vecs++;
        if (rd !== 32'h0) begin
            errs++; $display("FAIL rst_clear08 got=%h exp=0", rd);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_id();
        test_errors();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        repeat (2) @(negedge pclk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
